masked_share_encoder: RTL and testbench

MASKED_SHARE_ENCODER -- requirements
Module: masked_share_encoder

---
 rtl/masked_share_encoder.sv | 96 +++++++++
 tb/tb_masked_share_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_share_encoder.sv
// Boolean masking encoder: splits an unmasked word into security_order+1 shares
// using one beat of fresh randomness per word; shares leave from registers only.
module masked_share_encoder #(
   parameter int unsigned security_order = 1,
   parameter int unsigned width          = 8
) (
   input  logic                                                         clk,
   input  logic                                                         rst,
   input  logic [width-1:0]                                             in_data,
   input  logic                                                         in_valid,
   output logic                                                         in_ready,
   input  logic [((security_order == 0) ? 1 : security_order*width)-1:0] rnd,
   input  logic                                                         rnd_valid,
   output logic                                                         rnd_ready,
   output logic [(security_order+1)*width-1:0]                          out_shares,
   output logic                                                         out_valid,
   input  logic                                                         out_ready
);

   localparam int unsigned D    = security_order;
   localparam int unsigned N    = D + 1;
   localparam int unsigned SH_W = N * width;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      OUT      = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [width-1:0]  hold_q, hold_d;
   logic [SH_W-1:0]   shares_q, shares_d;
   logic [SH_W-1:0]   enc;

   // Share encoding: shares 1..d are raw randomness, share 0 absorbs the data
   for (genvar k = 0; k < int'(width); k++) begin : g_bit
      logic [D:0] sh;
      if (D == 0) begin : g_unmasked
         assign sh[0] = hold_q[k];
      end else begin : g_masked
         for (genvar s = 1; s <= int'(D); s++) begin : g_share
            assign sh[s] = rnd[k*int'(D) + s - 1];
         end
         assign sh[0] = hold_q[k] ^ (^sh[D:1]);
      end
      assign enc[k*int'(N) +: int'(N)] = sh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         shares_q <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         shares_q <= shares_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      shares_d  = shares_q;
      rnd_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               hold_d  = in_data;
               state_d = WAIT_RND;
            end
         end
         WAIT_RND: begin
            // With no masking there is nothing to wait for, so the beat is implicit
            rnd_ready = (D == 0) ? 1'b1 : rnd_valid;
            if (rnd_ready) begin
               shares_d = enc;
               state_d  = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               shares_d = '0;
               hold_d   = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == OUT);
   assign out_shares = shares_q;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Directed and randomized checks of masked_share_encoder in d=1/W=4, d=2/W=8 and d=0/W=8.
module tb_masked_share_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // d=1, W=4
   logic [3:0]  a_in_data;
   logic        a_in_valid, a_in_ready;
   logic [3:0]  a_rnd;
   logic        a_rnd_valid, a_rnd_ready;
   logic [7:0]  a_out_shares;
   logic        a_out_valid, a_out_ready;
   // d=2, W=8
   logic [7:0]  b_in_data;
   logic        b_in_valid, b_in_ready;
   logic [15:0] b_rnd;
   logic        b_rnd_valid, b_rnd_ready;
   logic [23:0] b_out_shares;
   logic        b_out_valid, b_out_ready;
   // d=0, W=8
   logic [7:0]  c_in_data;
   logic        c_in_valid, c_in_ready;
   logic [0:0]  c_rnd;
   logic        c_rnd_valid, c_rnd_ready;
   logic [7:0]  c_out_shares;
   logic        c_out_valid, c_out_ready;

   int n_cmp  = 0;
   int n_fail = 0;
   int c_pulses = 0;

   masked_share_encoder #(.security_order(1), .width(4)) u_a (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .rnd(a_rnd), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
      .out_shares(a_out_shares), .out_valid(a_out_valid), .out_ready(a_out_ready));

   masked_share_encoder #(.security_order(2), .width(8)) u_b (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
      .out_shares(b_out_shares), .out_valid(b_out_valid), .out_ready(b_out_ready));

   masked_share_encoder #(.security_order(0), .width(8)) u_c (
      .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .rnd(c_rnd), .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready),
      .out_shares(c_out_shares), .out_valid(c_out_valid), .out_ready(c_out_ready));

   always @(negedge clk) if (c_rnd_ready === 1'b1) c_pulses++;

   function automatic logic [23:0] model2(input logic [7:0] d, input logic [15:0] r);
      logic [23:0] e;
      e = '0;
      for (int k = 0; k < 8; k++) begin
         e[k*3+1] = r[k*2];
         e[k*3+2] = r[k*2+1];
         e[k*3]   = d[k] ^ r[k*2] ^ r[k*2+1];
      end
      return e;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_in_data = '0; a_in_valid = 0; a_rnd = '0; a_rnd_valid = 0; a_out_ready = 0;
      b_in_data = '0; b_in_valid = 0; b_rnd = '0; b_rnd_valid = 0; b_out_ready = 0;
      c_in_data = '0; c_in_valid = 0; c_rnd = '0; c_rnd_valid = 0; c_out_ready = 0;
      #12;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h00) begin n_fail++; $display("FAIL reset_shares: got %h want 00", a_out_shares); end
      n_cmp++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_ready: got %b want 0", a_rnd_ready); end
      n_cmp++; if (b_out_shares !== 24'h0) begin n_fail++; $display("FAIL reset_b_shares: got %h want 0", b_out_shares); end
      n_cmp++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_out_valid: got %b want 0", c_out_valid); end
      step;
      rst = 1'b0;
      step;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", a_in_ready); end
   endtask

   task automatic test_basic;
      a_out_ready = 1'b1;
      a_in_data = 4'hA; a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_wait_in_ready: got %b want 0", a_in_ready); end
      a_rnd = 4'h5; a_rnd_valid = 1'b1;
      #1;
      n_cmp++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rnd_ready: got %b want 1", a_rnd_ready); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", a_out_valid); end
      step;
      a_rnd_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h77) begin n_fail++; $display("FAIL basic_shares: got %h want 77", a_out_shares); end
      n_cmp++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rnd_ready_out: got %b want 0", a_rnd_ready); end
      step;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h00) begin n_fail++; $display("FAIL basic_cleared: got %h want 00", a_out_shares); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b want 1", a_in_ready); end
   endtask

   task automatic test_starvation;
      a_out_ready = 1'b1;
      a_in_data = 4'h6; a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0; a_rnd = 4'hF; a_rnd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL starve_rnd_ready[%0d]: got %b want 0", i, a_rnd_ready); end
         n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL starve_out_valid[%0d]: got %b want 0", i, a_out_valid); end
         step;
      end
      a_rnd = 4'h3; a_rnd_valid = 1'b1;
      step;
      a_rnd_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL starve_out_valid_end: got %b want 1", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h1B) begin n_fail++; $display("FAIL starve_shares: got %h want 1b", a_out_shares); end
      step;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL starve_done: got %b want 0", a_out_valid); end
   endtask

   task automatic test_backpressure;
      a_out_ready = 1'b0;
      a_in_data = 4'h9; a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0; a_rnd = 4'hC; a_rnd_valid = 1'b1;
      step;
      a_rnd_valid = 1'b0;
      a_in_data = 4'h2; a_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (a_out_shares !== 8'hB1) begin n_fail++; $display("FAIL bp_shares[%0d]: got %h want b1", i, a_out_shares); end
         n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, a_out_valid); end
         n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, a_in_ready); end
         step;
      end
      n_cmp++; if (a_out_shares !== 8'hB1) begin n_fail++; $display("FAIL bp_shares_hold: got %h want b1", a_out_shares); end
      a_out_ready = 1'b1;
      step;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_transfer: got %b want 0", a_out_valid); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", a_in_ready); end
      step;
      a_in_valid = 1'b0;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got %b want 0", a_in_ready); end
      a_rnd = 4'h0; a_rnd_valid = 1'b1;
      step;
      a_rnd_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h04) begin n_fail++; $display("FAIL bp_second_shares: got %h want 04", a_out_shares); end
      step;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_done: got %b want 1", a_in_ready); end
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", a_out_valid); end
   endtask

   task automatic test_reset_mid;
      a_out_ready = 1'b1;
      a_in_data = 4'h5; a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0; a_rnd = 4'hA; a_rnd_valid = 1'b1;
      #1;
      n_cmp++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_rnd_ready_pre: got %b want 1", a_rnd_ready); end
      rst = 1'b1;
      #1;
      n_cmp++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL rm_wait_rnd_ready: got %b want 0", a_rnd_ready); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wait_in_ready: got %b want 1", a_in_ready); end
      step;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait_ghost[%0d]: got %b want 0", i, a_out_valid); end
         n_cmp++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL rm_wait_rnd[%0d]: got %b want 0", i, a_rnd_ready); end
         n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wait_idle[%0d]: got %b want 1", i, a_in_ready); end
         step;
      end
      a_rnd_valid = 1'b0;
      a_out_ready = 1'b0;
      a_in_data = 4'h7; a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0; a_rnd = 4'h1; a_rnd_valid = 1'b1;
      step;
      a_rnd_valid = 1'b0;
      n_cmp++; if (a_out_shares !== 8'h16) begin n_fail++; $display("FAIL rm_out_shares: got %h want 16", a_out_shares); end
      rst = 1'b1;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_shares !== 8'h00) begin n_fail++; $display("FAIL rm_out_cleared: got %h want 00", a_out_shares); end
      a_out_ready = 1'b1;
      step;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_ghost[%0d]: got %b want 0", i, a_out_valid); end
         step;
      end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_out_idle: got %b want 1", a_in_ready); end
   endtask

   task automatic test_d0;
      logic [7:0] vals [2];
      int p0;
      vals[0] = 8'h3C; vals[1] = 8'hA5;
      p0 = c_pulses;
      c_out_ready = 1'b1; c_rnd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         c_in_data = vals[i]; c_in_valid = 1'b1;
         step;
         c_in_valid = 1'b0;
         n_cmp++; if (c_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL d0_rnd_ready[%0d]: got %b want 1", i, c_rnd_ready); end
         step;
         n_cmp++; if (c_out_valid !== 1'b1) begin n_fail++; $display("FAIL d0_out_valid[%0d]: got %b want 1", i, c_out_valid); end
         n_cmp++; if (c_out_shares !== vals[i]) begin n_fail++; $display("FAIL d0_shares[%0d]: got %h want %h", i, c_out_shares, vals[i]); end
         step;
         n_cmp++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL d0_done[%0d]: got %b want 0", i, c_out_valid); end
      end
      step;
      n_cmp++; if ((c_pulses - p0) !== 2) begin n_fail++; $display("FAIL d0_rnd_pulses: got %0d want 2", c_pulses - p0); end
   endtask

   task automatic test_random;
      logic [7:0]  dq [$];
      logic [15:0] rq [$];
      logic [7:0]  d;
      logic [15:0] r;
      logic [23:0] exp_sh;
      int cyc = 0, n_in = 0, n_rnd = 0, n_out = 0;
      while (n_out < 1000 && cyc < 30000) begin
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_data   = 8'($urandom);
         b_rnd_valid = ($urandom_range(0, 2) != 0);
         b_rnd       = 16'($urandom);
         b_out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (b_in_valid && b_in_ready) begin dq.push_back(b_in_data); n_in++; end
         if (b_rnd_valid && b_rnd_ready) begin rq.push_back(b_rnd); n_rnd++; end
         if (b_out_valid && b_out_ready) begin
            n_cmp++;
            if (dq.size() == 0 || rq.size() == 0) begin
               n_fail++; $display("FAIL rand_spurious_out: got %h want no output", b_out_shares);
            end else begin
               d = dq.pop_front();
               r = rq.pop_front();
               exp_sh = model2(d, r);
               if (b_out_shares !== exp_sh) begin
                  n_fail++; $display("FAIL rand_word[%0d]: got %h want %h", n_out, b_out_shares, exp_sh);
               end
            end
            n_out++;
         end
         step;
         cyc++;
      end
      b_in_valid = 1'b0; b_rnd_valid = 1'b0; b_out_ready = 1'b0;
      n_cmp++; if (n_out !== 1000) begin n_fail++; $display("FAIL rand_budget: got %0d words want 1000", n_out); end
      n_cmp++; if (n_in !== n_out) begin n_fail++; $display("FAIL rand_in_count: got %0d want %0d", n_in, n_out); end
      n_cmp++; if (n_rnd !== n_out) begin n_fail++; $display("FAIL rand_rnd_beats: got %0d want %0d", n_rnd, n_out); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_starvation();
      test_backpressure();
      test_reset_mid();
      test_d0();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
